// File: rtl/stream_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stream_pkg : shared helpers for the stream width converters.
// Rev 1.0
// ---------------------------------------------------------------------------
package stream_pkg;

   localparam int MAX_LANES = 32;

   function automatic int lane_idx_w(input int ratio);
      return (ratio > 1) ? $clog2(ratio) : 1;
   endfunction

   function automatic int popcount(input logic [MAX_LANES-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < MAX_LANES; i++) begin
         n = n + int'(v[i]);
      end
      return n;
   endfunction

   function automatic logic is_onehot(input logic [MAX_LANES-1:0] v);
      return (v != '0) && ((v & (v - MAX_LANES'(1))) == '0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/lane_prio_enc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lane_prio_enc : lowest-set-bit encoder with one-hot flag.
// Rev 1.0
// ---------------------------------------------------------------------------
module lane_prio_enc
   import stream_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int IDX_W = 2
) (
   input  logic [WIDTH-1:0] req_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             onehot_o
);

   // Scan downwards so the lowest set bit is the last to write.
   always_comb begin
      idx_o = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o = IDX_W'(i);
         end
      end
   end

   assign onehot_o = is_onehot(MAX_LANES'(req_i));

endmodule
`default_nettype wire

// File: rtl/stream_downsize.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stream_downsize : wide beat -> kept lanes, one narrow word per cycle.
// Optional STREAM_DOWNSIZE_SPARSE_KEEP_EN allows non-contiguous keep. Rev 1.0
// ---------------------------------------------------------------------------
module stream_downsize
   import stream_pkg::*;
#(
   parameter int T_DATA_WIDTH = 4,
   parameter int T_DATA_RATIO = 3
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] s_data_i,
   input  logic [T_DATA_RATIO-1:0]                   s_keep_i,
   input  logic                                      s_last_i,
   input  logic                                      s_valid_i,
   output logic                                      s_ready_o,
   output logic [T_DATA_WIDTH-1:0]                   m_data_o,
   output logic                                      m_last_o,
   output logic                                      m_valid_o,
   input  logic                                      m_ready_i
);

   localparam int IDX_W = lane_idx_w(T_DATA_RATIO);

   logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] buf_data_q, buf_data_d;
   logic                                      buf_last_q, buf_last_d;
   logic [T_DATA_RATIO-1:0]                   pend_q, pend_d;
   logic [T_DATA_RATIO-1:0]                   w_eff_keep;
   logic [IDX_W-1:0]                          w_lane;
   logic                                      w_onehot;
   logic                                      w_accept;
   logic                                      w_take;

`ifdef STREAM_DOWNSIZE_SPARSE_KEEP_EN
   assign w_eff_keep = s_keep_i;

   lane_prio_enc #(
      .WIDTH (T_DATA_RATIO),
      .IDX_W (IDX_W)
   ) u_lane_prio_enc (
      .req_i    (pend_q),
      .idx_o    (w_lane),
      .onehot_o (w_onehot)
   );
`else
   logic [IDX_W-1:0] cnt_q, cnt_d;

   // Only the leading run of kept lanes counts; pend stays a contiguous
   // suffix, so the current lane is simply the number of words sent.
   always_comb begin
      logic run_ok;
      run_ok     = 1'b1;
      w_eff_keep = '0;
      for (int i = 0; i < T_DATA_RATIO; i++) begin
         run_ok        = run_ok & s_keep_i[i];
         w_eff_keep[i] = run_ok;
      end
   end

   assign w_lane   = cnt_q;
   assign w_onehot = is_onehot(MAX_LANES'(pend_q));

   always_comb begin
      cnt_d = cnt_q;
      if (w_take) begin
         cnt_d = cnt_q + IDX_W'(1);
      end
      if (w_accept) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   assign m_valid_o = |pend_q;
   assign m_data_o  = buf_data_q[w_lane];
   assign m_last_o  = buf_last_q & w_onehot;
   assign s_ready_o = ~(|pend_q) | (w_onehot & m_ready_i);

   assign w_take    = m_valid_o & m_ready_i;
   assign w_accept  = s_valid_i & s_ready_o;

   always_comb begin
      buf_data_d = buf_data_q;
      buf_last_d = buf_last_q;
      pend_d     = pend_q;
      if (w_take) begin
         pend_d = pend_q & (pend_q - T_DATA_RATIO'(1));
      end
      // A new beat overrides the clear of the final pending lane.
      if (w_accept) begin
         buf_data_d = s_data_i;
         buf_last_d = s_last_i;
         pend_d     = w_eff_keep;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_data_q <= '0;
         buf_last_q <= 1'b0;
         pend_q     <= '0;
      end else begin
         buf_data_q <= buf_data_d;
         buf_last_q <= buf_last_d;
         pend_q     <= pend_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_stream_downsize.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_stream_downsize : directed self-checking bench for stream_downsize.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_stream_downsize;

   logic            clk;
   logic            rst;
   logic [2:0][3:0] s_data;
   logic [2:0]      s_keep;
   logic            s_last;
   logic            s_valid;
   logic            s_ready;
   logic [3:0]      m_data;
   logic            m_last;
   logic            m_valid;
   logic            m_ready;

   int n_tests;
   int n_fail;

   stream_downsize #(
      .T_DATA_WIDTH (4),
      .T_DATA_RATIO (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .s_data_i  (s_data),
      .s_keep_i  (s_keep),
      .s_last_i  (s_last),
      .s_valid_i (s_valid),
      .s_ready_o (s_ready),
      .m_data_o  (m_data),
      .m_last_o  (m_last),
      .m_valid_o (m_valid),
      .m_ready_i (m_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, then settle inputs away from it.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic word(input string tag, input logic [3:0] d, input logic l, input logic rdy);
      #1;
      chk({tag, ".valid"}, 32'(m_valid), 32'd1);
      chk({tag, ".data"},  32'(m_data),  32'(d));
      chk({tag, ".last"},  32'(m_last),  32'(l));
      chk({tag, ".ready"}, 32'(s_ready), 32'(rdy));
   endtask

   task automatic idle(input string tag);
      #1;
      chk({tag, ".valid"}, 32'(m_valid), 32'd0);
      chk({tag, ".ready"}, 32'(s_ready), 32'd1);
   endtask

   task automatic beat(input logic [11:0] d, input logic [2:0] k, input logic l);
      s_data  = d;
      s_keep  = k;
      s_last  = l;
      s_valid = 1'b1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      s_data  = '0;
      s_keep  = '0;
      s_last  = 1'b0;
      s_valid = 1'b0;
      m_ready = 1'b1;

      cyc();
      cyc();
      #1;
      chk("rst.valid", 32'(m_valid), 32'd0);
      chk("rst.last",  32'(m_last),  32'd0);
      chk("rst.data",  32'(m_data),  32'd0);
      chk("rst.ready", 32'(s_ready), 32'd1);
      rst = 1'b0;

      // Full beat {1,2,3} with last.
      cyc();
      beat(12'h321, 3'b111, 1'b1);
      cyc(); s_valid = 1'b0;
      word("full.w0", 4'h1, 1'b0, 1'b0);
      cyc(); word("full.w1", 4'h2, 1'b0, 1'b0);
      cyc(); word("full.w2", 4'h3, 1'b1, 1'b1);
      cyc(); idle("full.end");

      // Back-to-back {1,2,3} then {4,5,6}.
      beat(12'h321, 3'b111, 1'b0);
      cyc(); beat(12'h654, 3'b111, 1'b1);
      word("b2b.w0", 4'h1, 1'b0, 1'b0);
      cyc(); word("b2b.w1", 4'h2, 1'b0, 1'b0);
      cyc(); word("b2b.w2", 4'h3, 1'b0, 1'b1);
      cyc(); s_valid = 1'b0;
      word("b2b.w3", 4'h4, 1'b0, 1'b0);
      cyc(); word("b2b.w4", 4'h5, 1'b0, 1'b0);
      cyc(); word("b2b.w5", 4'h6, 1'b1, 1'b1);
      cyc(); idle("b2b.end");

      // Partial beat {7,8,9}, keep 011.
      beat(12'h987, 3'b011, 1'b1);
      cyc(); s_valid = 1'b0;
      word("part.w0", 4'h7, 1'b0, 1'b0);
      cyc(); word("part.w1", 4'h8, 1'b1, 1'b1);
      cyc(); idle("part.end");

      // Backpressure {A,B,C}, ready 0,1,0,0,1,1.
      beat(12'hCBA, 3'b111, 1'b1);
      cyc(); s_valid = 1'b0; m_ready = 1'b0;
      word("bp.c0", 4'hA, 1'b0, 1'b0);
      cyc(); m_ready = 1'b1;
      word("bp.c1", 4'hA, 1'b0, 1'b0);
      cyc(); m_ready = 1'b0;
      word("bp.c2", 4'hB, 1'b0, 1'b0);
      cyc(); word("bp.c3", 4'hB, 1'b0, 1'b0);
      cyc(); m_ready = 1'b1;
      word("bp.c4", 4'hB, 1'b0, 1'b0);
      cyc(); word("bp.c5", 4'hC, 1'b1, 1'b1);
      cyc(); idle("bp.end");

      // Sparse keep 101.
      beat(12'h321, 3'b101, 1'b1);
      cyc(); s_valid = 1'b0;
`ifdef STREAM_DOWNSIZE_SPARSE_KEEP_EN
      word("sparse.w0", 4'h1, 1'b0, 1'b0);
      cyc(); word("sparse.w1", 4'h3, 1'b1, 1'b1);
`else
      word("sparse.w0", 4'h1, 1'b1, 1'b1);
`endif
      cyc(); idle("sparse.end");

      // Reset after the first word.
      beat(12'h321, 3'b111, 1'b1);
      cyc(); s_valid = 1'b0;
      word("rstmid.w0", 4'h1, 1'b0, 1'b0);
      rst = 1'b1;
      cyc(); rst = 1'b0;
      idle("rstmid.after");
      beat(12'h654, 3'b111, 1'b1);
      cyc(); s_valid = 1'b0;
      word("post.w0", 4'h4, 1'b0, 1'b0);
      cyc(); word("post.w1", 4'h5, 1'b0, 1'b0);
      cyc(); word("post.w2", 4'h6, 1'b1, 1'b1);
      cyc(); idle("post.end");

      // Empty beat: accepted immediately, no output.
      beat(12'h777, 3'b000, 1'b0);
      #1;
      chk("empty.ready", 32'(s_ready), 32'd1);
      cyc(); s_valid = 1'b0;
      idle("empty.c1");
      cyc(); idle("empty.c2");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/stream_downsize.md
# stream_downsize

Width-reducing AXI-Stream-style converter: accepts one wide beat of `T_DATA_RATIO` lanes of `T_DATA_WIDTH` bits, with a per-lane keep mask and a last flag. It emits only the kept lanes, one narrow word per cycle, in ascending lane order. It is the inverse of `stream_upsize` and sits on the egress side of wide datapaths, feeding narrow stream consumers.

## Interface
- `T_DATA_WIDTH`, 4: width of one lane / narrow word.
- `T_DATA_RATIO`, 3: lanes per wide beat; must be ≥ 2.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `s_data_i`  in  `[T_DATA_WIDTH-1:0]` × `[T_DATA_RATIO-1:0]`  wide beat; lane 0 is sent first.
- `s_keep_i`  in  `T_DATA_RATIO`  lane-valid mask.
- `s_last_i`  in  1  beat ends the packet.
- `s_valid_i`  in  1  wide beat valid.
- `s_ready_o`  out  1  wide beat accepted when `s_valid_i && s_ready_o`.
- `m_data_o`  out  `T_DATA_WIDTH`  narrow word.
- `m_last_o`  out  1  final word of the packet.
- `m_valid_o`  out  1  narrow word valid.
- `m_ready_i`  in  1  narrow word consumed when `m_valid_o && m_ready_i`.

## Operation
- Internal state:
  - `buf_data`: registered copy of the wide beat.
  - `buf_last`: registered copy of `s_last_i`.
  - `pend`: `T_DATA_RATIO`-bit mask of lanes not yet sent.
  - Block is IDLE when `pend == 0`, otherwise SEND.
- Current lane is the lowest set bit of `pend`. The block drives:
  - `m_data_o = buf_data[lane]`
  - `m_valid_o = (pend != 0)`
  - `m_last_o = buf_last && pend is one-hot`
- Word handshake: on `m_valid_o && m_ready_i`, the current lane's bit is cleared from `pend`.
- `s_ready_o = (pend == 0) || (pend one-hot && m_ready_i)`. This is a combinational path from `m_ready_i` and allows back-to-back beats with no bubble.
- On beat acceptance:
  - Load `buf_data` and `buf_last`.
  - Load `pend` with the effective keep mask (see Configuration).
- A beat whose effective keep is 0 is accepted and produces no output; its `s_last_i` is discarded. Senders must not put `last` on an empty beat.
- Holding rule: while `m_valid_o && !m_ready_i`, `m_data_o` and `m_last_o` stay stable.
- Upstream must hold `s_data_i`, `s_keep_i` and `s_last_i` stable while `s_valid_i && !s_ready_o`.

## Timing
- Reset values: `m_valid_o=0`, `m_last_o=0`, `m_data_o=0`, `s_ready_o=1`, `pend=0`, `buf_*=0`.
- Latency: a beat accepted at edge N presents its first word from N+1. It occupies popcount(effective keep) cycles under `m_ready_i=1`.
- Throughput: one narrow word per cycle, sustained across beats.
- Simultaneous last-word handshake and new-beat acceptance in the same cycle: the new beat's first word appears at the next cycle.
- Reset mid-beat: the partial beat is dropped and no further words are emitted. The first cycle after `rst` deasserts is IDLE.
- `s_valid_i` low while IDLE: `m_valid_o` stays 0.

## Configuration
- `STREAM_DOWNSIZE_SPARSE_KEEP_EN` defined:
  - Effective keep is `s_keep_i` as given, so any pattern is allowed.
  - Zero lanes are skipped; set lanes are emitted in ascending order.
- Not defined:
  - Effective keep is the contiguous run of ones starting at lane 0; lanes at or above the first zero are ignored.
  - Example: keep `3'b101` yields lane 0 only.
  - The priority encoder reduces to a lane counter compared against the run length.

## Structure
- Shared package `stream_pkg`:
  - `localparam`/function for lane index width, `$clog2(T_DATA_RATIO)`.
  - Helpers for popcount and the one-hot check.
- Sub-module `lane_prio_enc`: parameterised lowest-set-bit encoder producing the lane index and a one-hot flag. It is instantiated only when `STREAM_DOWNSIZE_SPARSE_KEEP_EN` is defined.
- Top holds the buffers, `pend` and the handshake logic.

## Test plan
Defaults (W=4, R=3), `m_ready_i=1` unless stated.
- Full beat: lanes {1,2,3}, keep `111`, last → `m_data_o` 1,2,3 on three consecutive cycles; `m_last_o` only with 3; `s_ready_o` low for exactly 2 cycles.
- Two back-to-back full beats {1,2,3} then {4,5,6}, last on the second → 6 consecutive words with no bubble; `m_last_o` only on 6.
- Partial beat {7,8,9}, keep `011`, last → words 7,8; `m_last_o` on 8; 9 never appears.
- Backpressure on full beat {A,B,C}, `m_ready_i` pattern 0,1,0,0,1,1 → each word held stable while stalled; order A,B,C; no loss or duplication.
- Sparse beat {1,2,3}, keep `101`, last:
  - With macro → 1, 3 (last on 3).
  - Without macro → 1 only, with last.
- Reset asserted after the first word of {1,2,3}:
  - Next cycle `m_valid_o=0`.
  - A post-reset beat {4,5,6} emits 4,5,6 cleanly.
  - A keep `000` beat is accepted in one cycle with no output.
